fft_reorder: RTL and testbench

- Bit-reversal reorder buffer for the radix-2^2 SDF FFT pipeline.
- Sits directly after the last SDF stage. It accepts complete N-point frames in bit-reversed bin order and replays each frame in natural bin order (bin 0 first).
- Uses a ping-pong pair of N-entry banks, so back-to-back input frames stream out with no gap.

---
 rtl/fft_reorder.sv | 92 +++++++++
 tb/tb_fft_reorder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - bit-reversal reorder buffer, ping-pong banks, natural-order replay
module fft_reorder #(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             drop
);
    localparam int LOG_N = $clog2(N);
    localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);
    localparam logic [LOG_N-1:0] ONE  = LOG_N'(1);

    typedef enum logic {IDLE, READ} state_t;

    state_t             state_q, state_d;
    logic               wr_bank, rd_bank;
    logic [LOG_N-1:0]   wr_count, rd_count;
    logic               frame_done, partial;
    logic [2*WIDTH-1:0] rd_data;

    // Both banks in one array; the bank bit is the address MSB.
    logic [2*WIDTH-1:0] mem [0:2*N-1];

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) r[i] = a[LOG_N-1-i];
        return r;
    endfunction

    assign frame_done = di_en && (wr_count == LAST);
    assign partial    = !di_en && (wr_count != '0);
    assign rd_data    = mem[{rd_bank, rd_count}];

    always_ff @(posedge clock) begin
        if (di_en) mem[{wr_bank, bitrev(wr_count)}] <= {di_re, di_im};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
            wr_bank  <= 1'b0;
            drop     <= 1'b0;
        end else begin
            drop <= partial;
            if (di_en) begin
                wr_count <= wr_count + ONE;
                if (frame_done) wr_bank <= ~wr_bank;
            end else begin
                wr_count <= '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_done) state_d = READ;
            READ:    if (rd_count == LAST && !frame_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_count <= '0;
            rd_bank  <= 1'b0;
            do_en    <= 1'b0;
            do_re    <= '0;
            do_im    <= '0;
        end else begin
            state_q <= state_d;
            do_en   <= (state_q == READ);
            if (state_q == READ) begin
                {do_re, do_im} <= rd_data;
                rd_count       <= rd_count + ONE;
            end
            // A completing frame restarts the read even on the last read of the previous one.
            if (frame_done) begin
                rd_bank  <= wr_bank;
                rd_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - directed self-checking bench for fft_reorder
module tb_fft_reorder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        d8_en = 1'b0, d64_en = 1'b0;
    logic [15:0] d8_re = '0, d8_im = '0, d64_re = '0, d64_im = '0;
    logic        o8_en, o64_en, drop8, drop64;
    logic [15:0] o8_re, o8_im, o64_re, o64_im;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int drop8_cnt = 0, drop8_cyc = -1, drop64_cnt = 0;

    typedef struct {int re; int im; int cyc;} smp_t;
    smp_t q8[$];
    smp_t q64[$];

    logic [15:0] exp_re [2][64];
    logic [15:0] exp_im [2][64];
    int br8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_reorder #(.N(8), .WIDTH(16)) u8 (
        .clock(clock), .reset(reset), .di_en(d8_en), .di_re(d8_re), .di_im(d8_im),
        .do_en(o8_en), .do_re(o8_re), .do_im(o8_im), .drop(drop8));

    fft_reorder #(.N(64), .WIDTH(16)) u64 (
        .clock(clock), .reset(reset), .di_en(d64_en), .di_re(d64_re), .di_im(d64_im),
        .do_en(o64_en), .do_re(o64_re), .do_im(o64_im), .drop(drop64));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        smp_t s;
        if (o8_en) begin
            s.re = int'(o8_re); s.im = int'(o8_im); s.cyc = cyc;
            q8.push_back(s);
        end
        if (o64_en) begin
            s.re = int'(o64_re); s.im = int'(o64_im); s.cyc = cyc;
            q64.push_back(s);
        end
        if (drop8) begin
            drop8_cnt++;
            drop8_cyc = cyc;
        end
        if (drop64) drop64_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [5:0] bitrev6(input logic [5:0] k);
        return {k[0], k[1], k[2], k[3], k[4], k[5]};
    endfunction

    task automatic send8(input int base, output int first_in);
        first_in = cyc;
        for (int k = 0; k < 8; k++) begin
            d8_en = 1'b1;
            d8_re = 16'(base + br8[k]);
            d8_im = 16'(base + br8[k] + 100);
            tick();
        end
        d8_en = 1'b0;
    endtask

    task automatic send64(input int f, output int first_in);
        first_in = cyc;
        for (int k = 0; k < 64; k++) begin
            d64_en = 1'b1;
            d64_re = exp_re[f][bitrev6(6'(k))];
            d64_im = exp_im[f][bitrev6(6'(k))];
            tick();
        end
        d64_en = 1'b0;
    endtask

    task automatic check_q8(input string tag, input int n, input int first_cyc);
        check({tag, "_count"}, q8.size(), n);
        for (int i = 0; i < q8.size() && i < n; i++) begin
            check({tag, "_re"}, q8[i].re, i);
            check({tag, "_im"}, q8[i].im, i + 100);
            check({tag, "_cyc"}, q8[i].cyc, first_cyc + i);
        end
    endtask

    initial begin
        int a, b, c, p;
        bit seen;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a, b, p;
        bit seen;
        repeat (2) @(posedge clock);
        #1;
        check("reset_do_en8", o8_en, 0);
        check("reset_do_re8", o8_re, 0);
        check("reset_drop8", drop8, 0);
        check("reset_do_en64", o64_en, 0);
        check("reset_do_im64", o64_im, 0);
        reset = 1'b0;
        tick();

        // Basic single frame
        q8.delete();
        send8(0, a);
        repeat (12) tick();
        check_q8("basic", 8, a + 9);
        check("basic_drop", drop8_cnt, 0);

        // Three frames back to back: contiguous 0..23
        q8.delete();
        send8(0, a);
        send8(8, b);
        send8(16, b);
        repeat (14) tick();
        check("b2b_count", q8.size(), 24);
        for (int i = 0; i < q8.size() && i < 24; i++) begin
            check("b2b_re", q8[i].re, i);
            check("b2b_cyc", q8[i].cyc, a + 9 + i);
        end

        // Frame A, 5 idle cycles, frame B
        q8.delete();
        send8(0, a);
        repeat (5) tick();
        send8(8, b);
        repeat (12) tick();
        check("gap_count", q8.size(), 16);
        check("gap_a_first", (q8.size() > 0) ? q8[0].cyc : -1, a + 9);
        check("gap_b_first", (q8.size() > 8) ? q8[8].cyc : -1, b + 9);
        check("gap_idle_len", (q8.size() > 8) ? q8[8].cyc - q8[7].cyc : -1, 6);
        for (int i = 0; i < q8.size() && i < 16; i++) check("gap_re", q8[i].re, i);

        // Partial frame of 5, one idle cycle, then a full frame
        q8.delete();
        for (int k = 0; k < 5; k++) begin
            d8_en = 1'b1; d8_re = 16'(50 + k); d8_im = 16'(60 + k);
            tick();
        end
        d8_en = 1'b0;
        p = cyc;
        tick();
        send8(0, a);
        repeat (12) tick();
        check("partial_drop_cnt", drop8_cnt, 1);
        check("partial_drop_cyc", drop8_cyc, p + 1);
        check_q8("partial", 8, a + 9);

        // N=64: reset asserted while bin 20 is on the output
        for (int j = 0; j < 64; j++) begin
            exp_re[0][j] = 16'h1000 + 16'(j);
            exp_im[0][j] = 16'h2000 + 16'(3 * j);
        end
        q64.delete();
        send64(0, a);
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clock);
            #1;
            if (q64.size() >= 21) seen = 1'b1;
        end
        check("rst_bin20_seen", seen, 1);
        reset = 1'b1;
        #1;
        check("rst_async_en", o64_en, 0);
        check("rst_async_re", o64_re, 0);
        check("rst_async_im", o64_im, 0);
        check("rst_bins_before", q64.size(), 21);
        check("rst_bin20_val", (q64.size() > 20) ? q64[20].re : -1, 32'h1014);
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rst_no_more_out", q64.size(), 21);

        for (int j = 0; j < 64; j++) begin
            exp_re[0][j] = 16'h3000 + 16'(j);
            exp_im[0][j] = 16'hC000 - 16'(j);
        end
        q64.delete();
        send64(0, a);
        repeat (70) tick();
        check("post_rst_count", q64.size(), 64);
        check("post_rst_latency", (q64.size() > 0) ? q64[0].cyc : -1, a + 65);
        for (int j = 0; j < q64.size() && j < 64; j++) begin
            check("post_rst_re", q64[j].re, int'(exp_re[0][j]));
            check("post_rst_im", q64[j].im, int'(exp_im[0][j]));
        end

        // Full-range extremes, two frames back to back
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 64; j++) begin
                exp_re[f][j] = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
                exp_im[f][j] = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
            end
        end
        exp_re[0][0] = 16'h8000; exp_re[0][1] = 16'h7FFF;
        exp_im[1][63] = 16'h8000; exp_im[1][62] = 16'h7FFF;
        q64.delete();
        send64(0, a);
        send64(1, b);
        repeat (70) tick();
        check("full_count", q64.size(), 128);
        for (int i = 0; i < q64.size() && i < 128; i++) begin
            check("full_re", q64[i].re, int'(exp_re[i / 64][i % 64]));
            check("full_im", q64[i].im, int'(exp_im[i / 64][i % 64]));
            check("full_cyc", q64[i].cyc, a + 65 + i);
        end
        check("full_drop64", drop64_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
